// File: rtl/sa_operand_loader.sv
// rtl/sa_operand_loader.sv - operand feeder and handshake master for the systolic matrix-multiply core
module sa_operand_loader #(
  parameter int DWIDTH = 64,
  parameter int N      = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_enb,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DWIDTH-1:0]        in_data,
  input  logic                     in_last,
  output logic [N*N*DWIDTH-1:0]    a_row,
  output logic [N*N*DWIDTH-1:0]    b_col,
  output logic                     enb_1,
  output logic                     enb_2_6,
  output logic                     enb_7_12,
  output logic                     load_en,
  input  logic                     cal_finish,
  input  logic [N*N*DWIDTH-1:0]    c_in,
  output logic [N*N*DWIDTH-1:0]    res_mat,
  output logic                     res_valid,
  output logic                     frame_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(N * N * DWIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [IW-1:0] widx;
  logic          last_elem;
  logic          take_a;
  logic          take_b;
  logic          capture;

  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign last_elem = (row == LAST) && (col == LAST);
  assign take_a    = (state == S_LOAD_A) && in_valid;
  assign take_b    = (state == S_LOAD_B) && in_valid;
  assign capture   = (state == S_COMPUTE) && cal_finish;
  // bit offset of element [row][col] in the flattened row-major arrays
  assign widx      = IW'(((int'(row) * N) + int'(col)) * DWIDTH);

  // Job sequencer: command accept, A then B load, wait for core, release load_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      enb_1     <= 1'b0;
      enb_2_6   <= 1'b0;
      enb_7_12  <= 1'b0;
      load_en   <= 1'b0;
      res_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            {enb_7_12, enb_2_6, enb_1} <= cmd_enb;
            frame_err <= 1'b0;
            row       <= '0;
            col       <= '0;
            state     <= S_LOAD_A;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_valid) begin
            // framing is only meaningful on the B stream; load completes by count regardless
            if ((state == S_LOAD_B) && (in_last != last_elem)) begin
              frame_err <= 1'b1;
            end
            if (last_elem) begin
              row <= '0;
              col <= '0;
              if (state == S_LOAD_A) begin
                state <= S_LOAD_B;
              end else begin
                state   <= S_COMPUTE;
                load_en <= 1'b1;
              end
            end else if (col == LAST) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (cal_finish) begin
            res_valid <= 1'b1;
            load_en   <= 1'b0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // hold load_en low until the core has dropped cal_finish
          if (!cal_finish) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand write-in and result capture; arrays hold their contents between jobs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_row   <= '0;
      b_col   <= '0;
      res_mat <= '0;
    end else begin
      if (take_a) begin
        a_row[widx +: DWIDTH] <= in_data;
      end
      if (take_b) begin
        b_col[widx +: DWIDTH] <= in_data;
      end
      if (capture) begin
        res_mat <= c_in;
      end
    end
  end

endmodule

// File: tb/tb_sa_operand_loader.sv
// tb/tb_sa_operand_loader.sv - randomized self-checking bench for sa_operand_loader with a behavioural core
module tb_sa_operand_loader;
  localparam int DW  = 64;
  localparam int N   = 12;
  localparam int NN  = N * N;
  localparam int W   = NN * DW;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_enb = 3'b000;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [W-1:0]  a_row;
  logic [W-1:0]  b_col;
  logic          enb_1;
  logic          enb_2_6;
  logic          enb_7_12;
  logic          load_en;
  logic          cal_finish = 1'b0;
  logic [W-1:0]  c_in = '0;
  logic [W-1:0]  res_mat;
  logic          res_valid;
  logic          frame_err;

  int  total = 0;
  int  bad   = 0;
  real sa [NN];
  real sb [NN];
  int  ccnt = 0;

  always #5 clk = ~clk;

  sa_operand_loader #(.DWIDTH(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_enb(cmd_enb),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .a_row(a_row), .b_col(b_col),
    .enb_1(enb_1), .enb_2_6(enb_2_6), .enb_7_12(enb_7_12),
    .load_en(load_en), .cal_finish(cal_finish), .c_in(c_in),
    .res_mat(res_mat), .res_valid(res_valid), .frame_err(frame_err)
  );

  task automatic fail(input string tag);
    bad++;
    $error("FAIL %s", tag);
  endtask

  // column groups: col0 <- bit0, cols1..5 <- bit1, cols6..11 <- bit2
  function automatic bit col_en(input int c, input logic [2:0] e);
    if (c == 0) return e[0];
    if (c <= 5) return e[1];
    return e[2];
  endfunction

  // behavioural core: C = A*B from the operands it is handed, disabled columns zeroed
  task automatic core_compute();
    real s;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 0.0;
        if (col_en(c, {enb_7_12, enb_2_6, enb_1})) begin
          for (int k = 0; k < N; k++) begin
            s = s + $bitstoreal(a_row[(r*N+k)*DW +: DW]) * $bitstoreal(b_col[(k*N+c)*DW +: DW]);
          end
        end
        c_in[(r*N+c)*DW +: DW] = $realtobits(s);
      end
    end
  endtask

  // core handshake: raise cal_finish LAT cycles after load_en, hold until load_en falls
  always @(negedge clk) begin
    if (!rst_n || !load_en) begin
      cal_finish = 1'b0;
      ccnt = 0;
    end else if (!cal_finish) begin
      ccnt++;
      if (ccnt == LAT) begin
        core_compute();
        cal_finish = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int res_mismatch(input logic [2:0] e);
    int  m;
    real s;
    m = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        s = 0.0;
        if (col_en(c, e)) begin
          for (int k = 0; k < N; k++) s = s + sa[r*N+k] * sb[k*N+c];
        end
        if (res_mat[(r*N+c)*DW +: DW] !== $realtobits(s)) m++;
      end
    end
    return m;
  endfunction

  function automatic int operand_mismatch();
    int m;
    m = 0;
    for (int i = 0; i < NN; i++) begin
      if (a_row[i*DW +: DW] !== $realtobits(sa[i])) m++;
      if (b_col[i*DW +: DW] !== $realtobits(sb[i])) m++;
    end
    return m;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    total++; if (load_en !== 1'b0) fail("rst_load_en");
    total++; if (cmd_ready !== 1'b1) fail("rst_cmd_ready");
    total++; if (in_ready !== 1'b0) fail("rst_in_ready");
    total++; if (res_valid !== 1'b0) fail("rst_res_valid");
    total++; if (frame_err !== 1'b0) fail("rst_frame_err");
    total++; if ({enb_7_12, enb_2_6, enb_1} !== 3'b000) fail("rst_enb");
    total++; if ((a_row !== '0) || (b_col !== '0) || (res_mat !== '0)) fail("rst_arrays_zero");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) fail("post_rst_cmd_ready");
    total++; if (load_en !== 1'b0) fail("post_rst_load_en");
  endtask

  // mode 0: A=I, B=k+1; mode 1: all ones; else random small integers
  task automatic run_job(input logic [2:0] enb, input int mode, input bit bp,
                         input int last_at, input int junk_at, input bit exp_ferr,
                         input bit keep_cmd, input int abort_word, input bit abort_compute);
    int t;
    int idx;
    int viol;
    bit got;
    for (int i = 0; i < NN; i++) begin
      case (mode)
        0:       begin sa[i] = ((i / N) == (i % N)) ? 1.0 : 0.0; sb[i] = real'(i + 1); end
        1:       begin sa[i] = 1.0; sb[i] = 1.0; end
        default: begin sa[i] = real'($urandom_range(7)); sb[i] = real'($urandom_range(7)); end
      endcase
    end
    viol = 0;
    cmd_valid = 1'b1;
    cmd_enb = enb;
    t = 0;
    while (!cmd_ready && t < 2000) begin
      if (in_ready) viol++;
      @(negedge clk);
      t++;
    end
    total++; if (t >= 2000) fail("cmd_accept_timeout");
    @(negedge clk);
    if (!keep_cmd) cmd_valid = 1'b0;
    total++; if (frame_err !== 1'b0) fail("frame_err_cleared_on_cmd");
    total++; if ({enb_7_12, enb_2_6, enb_1} !== enb) fail("enb_latched");

    idx = 0;
    t = 0;
    while (idx < 2*NN && t < 20000) begin
      if (idx == abort_word) begin
        do_reset();
        return;
      end
      in_valid = bp ? ($urandom_range(1) == 1) : 1'b1;
      in_data  = $realtobits((idx < NN) ? sa[idx] : sb[idx - NN]);
      in_last  = (idx == last_at) || (idx == junk_at);
      got = in_valid && in_ready;
      if (cmd_ready || !in_ready) viol++;
      if (got && idx == 2*NN-1) begin
        total++; if (load_en !== 1'b0) fail("load_en_low_before_last_word");
      end
      @(negedge clk);
      t++;
      if (got) idx++;
    end
    total++; if (idx != 2*NN) fail("words_consumed");
    in_valid = 1'b1;
    in_data  = '1;
    in_last  = 1'b0;
    total++; if (load_en !== 1'b1) fail("load_en_rise_after_last_word");
    total++; if (in_ready !== 1'b0) fail("in_ready_low_after_load");
    total++; if (operand_mismatch() != 0) fail("operands_loaded");

    if (abort_compute) begin
      @(negedge clk);
      @(negedge clk);
      do_reset();
      return;
    end

    t = 0;
    while (!res_valid && t < 1000) begin
      if (cmd_ready || in_ready || !load_en) viol++;
      @(negedge clk);
      t++;
    end
    total++; if (t >= 1000) fail("result_timeout");
    total++; if (load_en !== 1'b0) fail("load_en_fall_with_result");
    total++; if (cmd_ready !== 1'b0) fail("cmd_ready_low_in_release");
    total++; if (viol != 0) fail("handshake_violations");
    total++; if (res_mismatch(enb) != 0) fail("res_mat_vs_model");
    total++; if (operand_mismatch() != 0) fail("operands_stable");
    total++; if (frame_err !== exp_ferr) fail("frame_err");
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (res_valid !== 1'b0) fail("res_valid_one_cycle");
  endtask

  initial begin
    do_reset();

    run_job(3'b111, 0, 1'b0, 2*NN-1, -1, 1'b0, 1'b0, -1, 1'b0);
    total++; if (res_mat[(3*N+7)*DW +: DW] !== $realtobits(44.0)) fail("ident_elem_3_7");

    run_job(3'b001, 1, 1'b0, 2*NN-1, -1, 1'b0, 1'b0, -1, 1'b0);
    total++; if (res_mat[(5*N+0)*DW +: DW] !== $realtobits(12.0)) fail("gate_col0");
    total++; if (res_mat[(5*N+1)*DW +: DW] !== 64'h0) fail("gate_col1_zero");
    total++; if (res_mat[(11*N+11)*DW +: DW] !== 64'h0) fail("gate_col11_zero");

    run_job(3'b111, 0, 1'b1, 2*NN-1, -1, 1'b0, 1'b0, -1, 1'b0);
    total++; if (res_mat[(11*N+11)*DW +: DW] !== $realtobits(144.0)) fail("bp_ident_elem_11_11");

    run_job(3'b110, 2, 1'b1, 2*NN-1, 50, 1'b0, 1'b0, -1, 1'b0);

    run_job(3'b111, 2, 1'b0, 200, -1, 1'b1, 1'b0, -1, 1'b0);
    total++; if (frame_err !== 1'b1) fail("frame_err_sticky_idle");
    run_job(3'b111, 2, 1'b0, 2*NN-1, -1, 1'b0, 1'b0, -1, 1'b0);

    run_job(3'b101, 2, 1'b0, 2*NN-1, -1, 1'b0, 1'b1, -1, 1'b0);
    run_job(3'b011, 2, 1'b1, 2*NN-1, -1, 1'b0, 1'b0, -1, 1'b0);

    run_job(3'b111, 2, 1'b0, 2*NN-1, -1, 1'b0, 1'b0, 200, 1'b0);
    run_job(3'b111, 2, 1'b1, 2*NN-1, -1, 1'b0, 1'b0, -1, 1'b1);
    run_job(3'b111, 2, 1'b0, 2*NN-1, -1, 1'b0, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
